// File: rtl/mem_if_pkg.sv
// Shared types for the tiny-SoC req/gnt memory port and the stream loader FSM.
package mem_if_pkg;

  localparam int StrbWidth = 8;

  typedef logic [31:0]          addr_t;
  typedef logic [63:0]          data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// Collects stream bytes into one 64-bit word with per-lane strobes.
// A clear restarts the word at a chosen lane. A clear wins over a load in the same cycle.
module byte_lane_packer
  import mem_if_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic [2:0] clear_lane_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic [2:0] lane_o,
  output data_t      data_o,
  output strb_t      strb_o
);

  logic [2:0] lane_q;
  data_t      data_q;
  strb_t      strb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= 3'd0;
      data_q <= '0;
      strb_q <= '0;
    end else if (clear_i) begin
      lane_q <= clear_lane_i;
      data_q <= '0;
      strb_q <= '0;
    end else if (load_i) begin
      data_q[{lane_q, 3'b000} +: 8] <= byte_i;
      strb_q[lane_q]                <= 1'b1;
      lane_q                        <= lane_q + 3'd1;
    end
  end

  assign lane_o = lane_q;
  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

// File: rtl/mem_stream_loader.sv
// Turns a byte stream into 64-bit strobed writes on the req/gnt memory port.
// All outputs come from registered state, so there is no path from byte_* or mem_gnt_i to an output.
//
// state   | meaning
// S_IDLE  | waiting for start_i
// S_FILL  | accepting bytes into the current word
// S_ISSUE | write request held until granted
// S_DONE  | one-cycle done pulse
module mem_stream_loader
  import mem_if_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_last_i,
  output logic                 byte_ready_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbWidth-1:0] mem_strb_o,
  output logic                 mem_we_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          words_o
);

  loader_state_e        state_q, state_d;
  logic [AddrWidth-4:0] word_addr_q;
  logic                 last_q;
  logic [31:0]          words_q;

  logic       accept, word_end, granted, start_load;
  logic [2:0] lane;
  data_t      pack_data;
  strb_t      pack_strb;

  assign start_load = (state_q == S_IDLE) && start_i;
  assign accept     = (state_q == S_FILL) && byte_valid_i;
  assign word_end   = accept && ((lane == 3'd7) || byte_last_i);
  assign granted    = (state_q == S_ISSUE) && mem_gnt_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i)   state_d = S_FILL;
      S_FILL:  if (word_end)  state_d = S_ISSUE;
      S_ISSUE: if (mem_gnt_i) state_d = last_q ? S_DONE : S_FILL;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    mem_req_o    = 1'b0;
    done_o       = 1'b0;
    busy_o       = 1'b1;
    unique case (state_q)
      S_IDLE:  busy_o       = 1'b0;
      S_FILL:  byte_ready_o = 1'b1;
      S_ISSUE: mem_req_o    = 1'b1;
      S_DONE:  done_o       = 1'b1;
      default: busy_o       = 1'b0;
    endcase
  end

  // last_q follows every accepted byte; only the value at the word-ending byte matters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_addr_q <= '0;
      last_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      if (start_load) begin
        word_addr_q <= base_addr_i[AddrWidth-1:3];
        last_q      <= 1'b0;
        words_q     <= '0;
      end
      if (accept) last_q <= byte_last_i;
      if (granted) begin
        word_addr_q <= word_addr_q + 1'b1;
        words_q     <= words_q + 32'd1;
      end
    end
  end

  byte_lane_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_load || granted),
    .clear_lane_i (granted ? 3'd0 : base_addr_i[2:0]),
    .load_i       (accept),
    .byte_i       (byte_i),
    .lane_o       (lane),
    .data_o       (pack_data),
    .strb_o       (pack_strb)
  );

  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = {word_addr_q, 3'b000};
  assign mem_wdata_o = pack_data;
  assign mem_strb_o  = pack_strb;
  assign words_o     = words_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed bench for mem_stream_loader: writes are captured on the port and
// compared against hand-computed addresses, data and strobes.
module tb_mem_stream_loader;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, byte_valid_i, byte_last_i, mem_gnt_i;
  logic [31:0] base_addr_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, mem_req_o, mem_we_o, busy_o, done_o;
  logic [31:0] mem_addr_o, words_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_strb_o;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [63:0] wr_data[$];
  logic [7:0]  wr_strb[$];
  logic [7:0]  ua[4];
  int n0, d0;

  always #5 clk_i = ~clk_i;

  mem_stream_loader #(.AddrWidth(32), .DataWidth(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_strb_o   (mem_strb_o),
    .mem_we_o     (mem_we_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .words_o      (words_o)
  );

  always @(negedge clk_i) begin
    if (mem_req_o && mem_gnt_i) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_wdata_o);
      wr_strb.push_back(mem_strb_o);
    end
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    start_i     = 1'b1;
    base_addr_i = base;
    tick();
    start_i     = 1'b0;
    base_addr_i = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic rdy;
    rdy          = 1'b0;
    byte_valid_i = 1'b1;
    byte_i       = b;
    byte_last_i  = last;
    for (int i = 0; i < 40 && !rdy; i++) begin
      @(negedge clk_i);
      rdy = byte_ready_o;
      tick();
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    byte_i       = '0;
    if (!rdy) chk("byte_accept_timeout", rdy, 1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_i);
      seen = done_o;
    end
    if (!seen) chk("done_timeout", seen, 1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, byte_ready_o, 0);
    chk({tag, "_req"},   mem_req_o,    0);
    chk({tag, "_we"},    mem_we_o,     0);
    chk({tag, "_addr"},  mem_addr_o,   0);
    chk({tag, "_wdata"}, mem_wdata_o,  0);
    chk({tag, "_strb"},  mem_strb_o,   0);
    chk({tag, "_busy"},  busy_o,       0);
    chk({tag, "_done"},  done_o,       0);
    chk({tag, "_words"}, words_o,      0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_last_i = 1'b0;
    mem_gnt_i = 1'b0; base_addr_i = '0; byte_i = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_i = 1'b0;
    tick();

    // aligned full word
    mem_gnt_i = 1'b1;
    n0 = wr_addr.size(); d0 = done_cnt;
    do_start(32'h8000_0000);
    chk("t1_ready_after_start", byte_ready_o, 1);
    chk("t1_busy", busy_o, 1);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 7);
    chk("t1_req_after_word", mem_req_o, 1);
    chk("t1_we_after_word", mem_we_o, 1);
    chk("t1_ready_in_issue", byte_ready_o, 0);
    wait_done();
    chk("t1_nwrites", wr_addr.size() - n0, 1);
    chk("t1_addr", wr_addr[n0], 64'h8000_0000);
    chk("t1_data", wr_data[n0], 64'h0807_0605_0403_0201);
    chk("t1_strb", wr_strb[n0], 8'hFF);
    chk("t1_done_pulses", done_cnt - d0, 1);
    repeat (3) tick();
    chk("t1_words_kept", words_o, 1);
    chk("t1_idle_busy", busy_o, 0);

    // unaligned start
    ua = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    n0 = wr_addr.size();
    do_start(32'h8000_0005);
    for (int i = 0; i < 4; i++) send_byte(ua[i], i == 3);
    wait_done();
    chk("t2_nwrites", wr_addr.size() - n0, 2);
    chk("t2_addr0", wr_addr[n0], 64'h8000_0000);
    chk("t2_strb0", wr_strb[n0], 8'hE0);
    chk("t2_data0", wr_data[n0], 64'hCCBB_AA00_0000_0000);
    chk("t2_addr1", wr_addr[n0+1], 64'h8000_0008);
    chk("t2_strb1", wr_strb[n0+1], 8'h01);
    chk("t2_data1", wr_data[n0+1], 64'h0000_0000_0000_00DD);
    chk("t2_words", words_o, 2);

    // backpressure
    mem_gnt_i = 1'b0;
    n0 = wr_addr.size();
    do_start(32'h0000_0100);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), i == 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("t3_req_held", mem_req_o, 1);
      chk("t3_addr_held", mem_addr_o, 32'h0000_0100);
      chk("t3_data_held", mem_wdata_o, 64'h1817_1615_1413_1211);
      chk("t3_strb_held", mem_strb_o, 8'hFF);
      chk("t3_ready_low", byte_ready_o, 0);
      chk("t3_words_wait", words_o, 0);
      tick();
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("t3_words_after_gnt", words_o, 1);
    chk("t3_req_dropped", mem_req_o, 0);
    wait_done();
    chk("t3_nwrites", wr_addr.size() - n0, 1);
    chk("t3_words_final", words_o, 1);

    // address wrap
    mem_gnt_i = 1'b1;
    n0 = wr_addr.size();
    do_start(32'hFFFF_FFF8);
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_done();
    chk("t4_nwrites", wr_addr.size() - n0, 2);
    chk("t4_addr0", wr_addr[n0], 64'hFFFF_FFF8);
    chk("t4_addr1", wr_addr[n0+1], 64'h0000_0000);
    chk("t4_data1", wr_data[n0+1], 64'h0F0E_0D0C_0B0A_0908);
    chk("t4_words", words_o, 2);

    // reset while a request waits for grant
    mem_gnt_i = 1'b0;
    n0 = wr_addr.size();
    do_start(32'h0000_0200);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), i == 7);
    chk("t5_req_pending", mem_req_o, 1);
    rst_i = 1'b1;
    tick();
    chk_reset_outputs("t5_rst");
    rst_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    do_start(32'h0000_0040);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5B, 1'b1);
    wait_done();
    chk("t5_nwrites", wr_addr.size() - n0, 1);
    chk("t5_addr", wr_addr[n0], 64'h0000_0040);
    chk("t5_strb", wr_strb[n0], 8'h03);
    chk("t5_data", wr_data[n0], 64'h0000_0000_0000_5B5A);
    chk("t5_words", words_o, 1);

    // start during FILL is ignored
    n0 = wr_addr.size();
    do_start(32'h0000_1000);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b0);
    start_i = 1'b1; base_addr_i = 32'h0000_2000;
    tick();
    start_i = 1'b0; base_addr_i = '0;
    for (int i = 3; i < 8; i++) send_byte(8'(i + 1), i == 7);
    wait_done();
    chk("t6_nwrites", wr_addr.size() - n0, 1);
    chk("t6_addr", wr_addr[n0], 64'h0000_1000);
    chk("t6_data", wr_data[n0], 64'h0807_0605_0403_0201);
    chk("t6_words", words_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
